// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Shared iterative multiply/divide unit for the two issue lanes. Arbitrates
//   lane requests round-robin, runs one radix-2 shift-add (multiply) or
//   restoring shift-subtract (divide) step per cycle, applies the sign fix-up
//   and commits HI/LO before pulsing done back to the requesting lane.
//
//   Build option: MULDIV_EARLY_OUT_EN -- when defined, a multiply leaves CALC
//   as soon as no set multiplier bits remain (minimum one CALC cycle).
//
//   Ports
//     clk, rst_n              clock, asynchronous active-low reset
//     reqN_valid/op/a/b       lane N request (op: 00 MULT 01 MULTU 10 DIV 11 DIVU)
//     reqN_ready              lane N granted (accepted on valid & ready)
//     kill                    flush: aborts an operation in CALC or FIX
//     busy                    high in CALC, FIX and DONE
//     done, done_lane         one-cycle completion pulse and its lane
//     hi, lo                  HI/LO result registers
module muldiv_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic              done_lane,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_next;

  logic              ptr;
  logic              grant;
  logic              grant_valid;
  logic              can_accept;
  logic              accept;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_neg_a;
  logic              sel_neg_b;
  logic [DATA_W-1:0] sel_mag_a;
  logic [DATA_W-1:0] sel_mag_b;

  logic [CNT_W-1:0]    cnt;
  logic [1:0]          op_q;
  logic                lane_q;
  logic                neg_a_q;
  logic                neg_b_q;
  logic [DATA_W-1:0]   mag_a_q;
  logic [DATA_W-1:0]   mag_b_q;
  logic [2*DATA_W-1:0] prod_q;
  logic [2*DATA_W-1:0] mcand_q;
  // Multiplier (shifts right) for multiply; dividend/quotient (shifts left) for divide.
  logic [DATA_W-1:0]   work_q;
  logic [DATA_W-1:0]   rem_q;

  logic [2*DATA_W-1:0] mul_add;
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W+1:0]   rem_diff;
  logic                div_ge;
  logic                last_iter;
  logic                signs_differ;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   raw_a;
  logic                div_zero;

  // Arbitration: a lone valid lane wins, otherwise the pointer lane is granted.
  always_comb begin
    grant       = (req0_valid ^ req1_valid) ? req1_valid : ptr;
    grant_valid = grant ? req1_valid : req0_valid;
    can_accept  = (state == IDLE) && !kill;
    req0_ready  = can_accept && !grant;
    req1_ready  = can_accept && grant;
    accept      = can_accept && grant_valid;
    sel_op      = grant ? req1_op : req0_op;
    sel_a       = grant ? req1_a  : req0_a;
    sel_b       = grant ? req1_b  : req0_b;
    sel_neg_a   = !sel_op[0] && sel_a[DATA_W-1];
    sel_neg_b   = !sel_op[0] && sel_b[DATA_W-1];
    sel_mag_a   = sel_neg_a ? -sel_a : sel_a;
    sel_mag_b   = sel_neg_b ? -sel_b : sel_b;
  end

  always_comb begin
    mul_add   = work_q[0] ? (prod_q + mcand_q) : prod_q;
    rem_shift = {rem_q, work_q[DATA_W-1]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, mag_b_q};
    div_ge    = !rem_diff[DATA_W+1];
`ifdef MULDIV_EARLY_OUT_EN
    last_iter = (cnt == CNT_W'(DATA_W - 1)) ||
                (!op_q[1] && (work_q[DATA_W-1:1] == '0));
`else
    last_iter = (cnt == CNT_W'(DATA_W - 1));
`endif
    signs_differ = !op_q[0] && (neg_a_q ^ neg_b_q);
    prod_fix     = signs_differ ? -prod_q : prod_q;
    quo_fix      = signs_differ ? -work_q : work_q;
    rem_fix      = (!op_q[0] && neg_a_q) ? -rem_q : rem_q;
    raw_a        = neg_a_q ? -mag_a_q : mag_a_q;
    div_zero     = (mag_b_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (kill) state_next = IDLE;
               else if (last_iter) state_next = FIX;
      FIX:     state_next = kill ? IDLE : DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign done_lane = done && lane_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= 1'b0;
      cnt     <= '0;
      op_q    <= '0;
      lane_q  <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr     <= ~grant;
            lane_q  <= grant;
            op_q    <= sel_op;
            neg_a_q <= sel_neg_a;
            neg_b_q <= sel_neg_b;
            mag_a_q <= sel_mag_a;
            mag_b_q <= sel_mag_b;
            cnt     <= '0;
            prod_q  <= '0;
            rem_q   <= '0;
            mcand_q <= {{DATA_W{1'b0}}, sel_mag_a};
            work_q  <= sel_op[1] ? sel_mag_a : sel_mag_b;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[1]) begin
            rem_q  <= div_ge ? rem_diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
            work_q <= {work_q[DATA_W-2:0], div_ge};
          end else begin
            prod_q  <= mul_add;
            mcand_q <= mcand_q << 1;
            work_q  <= work_q >> 1;
          end
        end
        FIX: begin
          if (!kill) begin
            if (!op_q[1]) begin
              hi <= prod_fix[2*DATA_W-1:DATA_W];
              lo <= prod_fix[DATA_W-1:0];
            end else if (div_zero) begin
              hi <= raw_a;
              lo <= '1;
            end else begin
              // Signed overflow (MIN / -1) falls out naturally: |MIN| / 1
              // negated wraps back to MIN with a zero remainder.
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
